// File: rtl/multicycle_ctrl.sv
// Purpose : Moore control FSM for a MIPS-style multicycle datapath (fetch/decode/exec/mem/writeback).
// Latency : 3..5 cycles per instruction with memory ready at once; each memory-wait cycle adds one.
// Backpres: FETCH/MEM_RD/MEM_WR hold until mem_ready; a wait of MEM_TIMEOUT cycles ends in sticky ERR.
// Option  : define ILLEGAL_TRAP_EN to trap undecoded opcodes / R-type functs into TRAP (sticky illegal).
module multicycle_ctrl #(
    parameter int OP_W        = 6,
    parameter int MEM_TIMEOUT = 255
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [OP_W-1:0] opcode,
    input  logic [OP_W-1:0] funct,
    input  logic            zero,
    input  logic            mem_ready,
    output logic            pc_write,
    output logic            ir_write,
    output logic            iord,
    output logic            mem_read,
    output logic            mem_write,
    output logic            reg_write,
    output logic            mem_to_reg,
    output logic            wd_inp,
    output logic            alu_src_a,
    output logic [1:0]      pc_src,
    output logic [1:0]      reg_dst,
    output logic [1:0]      alu_src_b,
    output logic [1:0]      alu_op,
    output logic [3:0]      state,
    output logic            mem_err,
    output logic            illegal
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_EXEC_R = 4'd2,
        S_WB_R   = 4'd3,
        S_EXEC_I = 4'd4,
        S_WB_I   = 4'd5,
        S_ADDR   = 4'd6,
        S_MEM_RD = 4'd7,
        S_WB_LW  = 4'd8,
        S_MEM_WR = 4'd9,
        S_BRANCH = 4'd10,
        S_JUMP   = 4'd11,
        S_JAL    = 4'd12,
        S_JR     = 4'd13,
        S_ERR    = 4'd14,
        S_TRAP   = 4'd15
    } state_t;

    localparam logic [OP_W-1:0] OPC_R    = OP_W'(0);
    localparam logic [OP_W-1:0] OPC_J    = OP_W'(2);
    localparam logic [OP_W-1:0] OPC_JAL  = OP_W'(3);
    localparam logic [OP_W-1:0] OPC_BEQ  = OP_W'(4);
    localparam logic [OP_W-1:0] OPC_BNE  = OP_W'(5);
    localparam logic [OP_W-1:0] OPC_ADDI = OP_W'(8);
    localparam logic [OP_W-1:0] OPC_ANDI = OP_W'(12);
    localparam logic [OP_W-1:0] OPC_LW   = OP_W'(35);
    localparam logic [OP_W-1:0] OPC_SW   = OP_W'(43);
    localparam logic [OP_W-1:0] FN_JR    = OP_W'(8);

    state_t          r_state;
    state_t          w_next;
    logic [OP_W-1:0] r_op;        // opcode captured in DECODE for the later states
    logic [15:0]     r_cnt;       // memory-wait counter
    logic            r_mem_err;
    logic [16:0]     w_cnt_inc;
    logic            w_timeout;
    logic            w_wait_st;

    logic            w_pc_write, w_ir_write, w_iord, w_mem_read, w_mem_write;
    logic            w_reg_write, w_mem_to_reg, w_wd_inp, w_alu_src_a;
    logic [1:0]      w_pc_src, w_reg_dst, w_alu_src_b, w_alu_op;

    assign w_wait_st = (r_state == S_FETCH) || (r_state == S_MEM_RD) || (r_state == S_MEM_WR);
    assign w_cnt_inc = {1'b0, r_cnt} + 17'd1;
    // This stall cycle is the one that makes the counter hit the limit; mem_ready on it still wins.
    assign w_timeout = (w_cnt_inc >= 17'(MEM_TIMEOUT));

`ifdef ILLEGAL_TRAP_EN
    logic r_illegal;
    logic w_funct_ok;

    // R-type functs this datapath implements: add, sub, and, or, slt, jr.
    always_comb begin
        w_funct_ok = 1'b0;
        case (funct)
            OP_W'(8'h20), OP_W'(8'h22), OP_W'(8'h24),
            OP_W'(8'h25), OP_W'(8'h2A), OP_W'(8'h08): w_funct_ok = 1'b1;
            default:                                   w_funct_ok = 1'b0;
        endcase
    end
`endif

    // Next-state and Moore outputs; only the mem_ready-qualified strobes and BRANCH pc_write look at inputs.
    always_comb begin
        w_next       = r_state;
        w_pc_write   = 1'b0;
        w_ir_write   = 1'b0;
        w_iord       = 1'b0;
        w_mem_read   = 1'b0;
        w_mem_write  = 1'b0;
        w_reg_write  = 1'b0;
        w_mem_to_reg = 1'b0;
        w_wd_inp     = 1'b0;
        w_alu_src_a  = 1'b0;
        w_pc_src     = 2'b00;
        w_reg_dst    = 2'b00;
        w_alu_src_b  = 2'b00;
        w_alu_op     = 2'b00;
        case (r_state)
            S_FETCH: begin
                w_mem_read  = 1'b1;
                w_alu_src_b = 2'b01;
                if (mem_ready) begin
                    w_ir_write = 1'b1;
                    w_pc_write = 1'b1;
                    w_next     = S_DECODE;
                end else if (w_timeout) begin
                    w_next = S_ERR;
                end
            end
            S_DECODE: begin
                w_alu_src_b = 2'b11;
                case (opcode)
                    OPC_R: begin
                        if (funct == FN_JR) begin
                            w_next = S_JR;
                        end else begin
`ifdef ILLEGAL_TRAP_EN
                            w_next = w_funct_ok ? S_EXEC_R : S_TRAP;
`else
                            w_next = S_EXEC_R;
`endif
                        end
                    end
                    OPC_ADDI, OPC_ANDI: w_next = S_EXEC_I;
                    OPC_LW, OPC_SW:     w_next = S_ADDR;
                    OPC_BEQ, OPC_BNE:   w_next = S_BRANCH;
                    OPC_J:              w_next = S_JUMP;
                    OPC_JAL:            w_next = S_JAL;
`ifdef ILLEGAL_TRAP_EN
                    default:            w_next = S_TRAP;
`else
                    default:            w_next = S_FETCH;
`endif
                endcase
            end
            S_EXEC_R: begin
                w_alu_src_a = 1'b1;
                w_alu_op    = 2'b10;
                w_next      = S_WB_R;
            end
            S_WB_R: begin
                w_reg_dst   = 2'b01;
                w_reg_write = 1'b1;
                w_next      = S_FETCH;
            end
            S_EXEC_I: begin
                w_alu_src_a = 1'b1;
                w_alu_src_b = 2'b10;
                w_alu_op    = (r_op == OPC_ANDI) ? 2'b11 : 2'b00;
                w_next      = S_WB_I;
            end
            S_WB_I: begin
                w_reg_write = 1'b1;
                w_next      = S_FETCH;
            end
            S_ADDR: begin
                w_alu_src_a = 1'b1;
                w_alu_src_b = 2'b10;
                w_next      = (r_op == OPC_SW) ? S_MEM_WR : S_MEM_RD;
            end
            S_MEM_RD: begin
                w_iord     = 1'b1;
                w_mem_read = 1'b1;
                if (mem_ready)      w_next = S_WB_LW;
                else if (w_timeout) w_next = S_ERR;
            end
            S_WB_LW: begin
                w_mem_to_reg = 1'b1;
                w_reg_write  = 1'b1;
                w_next       = S_FETCH;
            end
            S_MEM_WR: begin
                w_iord      = 1'b1;
                w_mem_write = 1'b1;
                if (mem_ready)      w_next = S_FETCH;
                else if (w_timeout) w_next = S_ERR;
            end
            S_BRANCH: begin
                w_alu_src_a = 1'b1;
                w_alu_op    = 2'b01;
                w_pc_src    = 2'b01;
                w_pc_write  = (r_op == OPC_BNE) ? ~zero : zero;
                w_next      = S_FETCH;
            end
            S_JUMP: begin
                w_pc_src   = 2'b10;
                w_pc_write = 1'b1;
                w_next     = S_FETCH;
            end
            S_JAL: begin
                w_pc_src    = 2'b10;
                w_pc_write  = 1'b1;
                w_reg_dst   = 2'b10;
                w_wd_inp    = 1'b1;
                w_reg_write = 1'b1;
                w_next      = S_FETCH;
            end
            S_JR: begin
                w_pc_src   = 2'b11;
                w_pc_write = 1'b1;
                w_next     = S_FETCH;
            end
            S_ERR:   w_next = S_ERR;
            S_TRAP:  w_next = S_TRAP;
            default: w_next = S_FETCH;
        endcase
    end

    // State register, opcode capture, wait counter and sticky memory error.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_FETCH;
            r_op      <= '0;
            r_cnt     <= 16'd0;
            r_mem_err <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == S_DECODE) r_op <= opcode;
            // Counter only runs while stalled in a wait state; any other cycle leaves it at 0 for the next entry.
            if (w_wait_st && !mem_ready) r_cnt <= w_cnt_inc[15:0];
            else                         r_cnt <= 16'd0;
            if (w_next == S_ERR) r_mem_err <= 1'b1;
        end
    end

`ifdef ILLEGAL_TRAP_EN
    // Sticky illegal flag, set on the way into TRAP.
    always_ff @(posedge clk) begin
        if (rst)                  r_illegal <= 1'b0;
        else if (w_next == S_TRAP) r_illegal <= 1'b1;
    end
    assign illegal = r_illegal & ~rst;
`else
    assign illegal = 1'b0;
`endif

    // Strobes are forced low while reset is held, even before the first reset edge lands.
    assign pc_write   = w_pc_write  & ~rst;
    assign ir_write   = w_ir_write  & ~rst;
    assign mem_read   = w_mem_read  & ~rst;
    assign mem_write  = w_mem_write & ~rst;
    assign reg_write  = w_reg_write & ~rst;
    assign iord       = w_iord;
    assign mem_to_reg = w_mem_to_reg;
    assign wd_inp     = w_wd_inp;
    assign alu_src_a  = w_alu_src_a;
    assign pc_src     = w_pc_src;
    assign reg_dst    = w_reg_dst;
    assign alu_src_b  = w_alu_src_b;
    assign alu_op     = w_alu_op;
    assign state      = rst ? S_FETCH : r_state;
    assign mem_err    = r_mem_err & ~rst;

endmodule
